uart_rx_oversample: RTL and testbench
=====================================

UART_RX_OVERSAMPLE -- requirements
Module: uart_rx_oversample

Interface
REQ-001 SHALL have parameter CLKS_PER_BIT, default 5208, clk cycles per serial bit (min 8).
REQ-002 SHALL have parameter DATA_BITS, default 8, payload bits per frame.
REQ-003 SHALL have port clk  input  1  single system clock; all logic on posedge clk.
REQ-004 SHALL have port rst  input  1  asynchronous, active-high reset.
REQ-005 SHALL have port rxd  input  1  asynchronous serial line; idle high.
REQ-006 SHALL have port rx_ack  input  1  consumer acknowledge; clears rx_valid and overrun.
REQ-007 SHALL have port rx_data  output  DATA_BITS  last correctly framed byte, LSB received first.
REQ-008 SHALL have port rx_valid  output  1  level: rx_data holds an unacknowledged byte.
REQ-009 SHALL have port overrun  output  1  sticky: a byte completed while rx_valid was already 1.
REQ-010 SHALL have port frame_err  output  1  one-cycle pulse: stop bit sampled low.
REQ-011 SHALL have port rx_busy  output  1  high whenever FSM is not IDLE.

Function
REQ-012 SHALL pass rxd through a 2-flop synchronizer (reset value 1); the FSM sees only rxd_s.
REQ-013 SHALL implement FSM states IDLE, START, DATA, STOP, WAIT_HIGH.
REQ-014 IDLE: rxd_s==0 -> START, bit counter cleared, clock counter cleared.
REQ-015 START: after CLKS_PER_BIT/2 cycles (integer division), sample rxd_s; 0 -> DATA, 1 -> IDLE (glitch rejected, no output change).
REQ-016 DATA: sample rxd_s every CLKS_PER_BIT cycles into shift register, LSB first; after DATA_BITS samples -> STOP.
REQ-017 STOP: sample rxd_s after CLKS_PER_BIT cycles; 1 -> load rx_data, set rx_valid, -> IDLE in the same cycle (mid-stop re-arm for back-to-back frames).
REQ-018 STOP sampled 0 -> pulse frame_err one cycle, rx_data/rx_valid unchanged, -> WAIT_HIGH.
REQ-019 WAIT_HIGH: remain until rxd_s==1, then -> IDLE (break condition never re-triggers START).
REQ-020 Good stop while rx_valid==1 and rx_ack==0 -> overwrite rx_data with new byte, set overrun.
REQ-021 rx_ack==1 -> clear rx_valid and overrun next cycle; ack in the same cycle as a good stop -> rx_valid stays 1, overrun not set, rx_data takes new byte.
REQ-022 rx_ack while rx_valid==0 SHALL have no effect.
REQ-023 Clock counter SHALL be $clog2(CLKS_PER_BIT)+1 bits, wrap-free (cleared on every sample point).
REQ-024 Latency: rx_valid rises at the clk edge after the mid-stop sample; nominal 2 + CLKS_PER_BIT/2 + (DATA_BITS+1)*CLKS_PER_BIT cycles after rxd falls, +/-1 cycle.

Reset
REQ-025 rst SHALL asynchronously force FSM=IDLE, counters=0, shift register=0, rx_data=0, rx_valid=0, overrun=0, frame_err=0, rx_busy=0, synchronizer flops=1.
REQ-026 rst asserted mid-frame SHALL discard the partial byte; after release, the next falling edge on rxd starts a fresh frame.

Structure
REQ-027 FSM state encoding and default CLKS_PER_BIT SHALL live in the shared package uart_pkg, also used by the transmitter.
REQ-028 The synchronizer SHALL be a separate sub-module sync2 (parameterised reset value); all other logic flat.

Verification (CLKS_PER_BIT=16, DATA_BITS=8)
REQ-029 Frame 0xA5 with good stop -> rx_data=0xA5, rx_valid rises 154+/-1 cycles after rxd falls, frame_err never pulses.
REQ-030 rxd low for 4 cycles, then high -> FSM returns to IDLE, rx_valid=0, rx_busy high no longer than 12 cycles.
REQ-031 Frame 0x3C with stop=0, line held low 40 further cycles -> one frame_err pulse, rx_valid=0, no new START until rxd returns high.
REQ-032 Back-to-back 0x11 then 0x22, no ack -> rx_data=0x22, rx_valid=1, overrun=1; rx_ack pulse -> both cleared next cycle.
REQ-033 rst asserted during bit 4 of 0xFF, then full frame 0x5A -> rx_data=0x5A, overrun=0, no frame_err.

Source files
------------

// File: rtl/uart_pkg.sv
// Shared UART definitions, used by both the receiver and the transmitter.
//   CLKS_PER_BIT_DEFAULT : default clk cycles per serial bit
//   uart_rx_state_e      : receiver FSM state encoding
package uart_pkg;

  localparam int unsigned CLKS_PER_BIT_DEFAULT = 5208;

  typedef enum logic [2:0] {
    StIdle,
    StStart,
    StData,
    StStop,
    StWaitHigh
  } uart_rx_state_e;

endpackage

// File: rtl/sync2.sv
// Two-flop synchronizer for a single asynchronous input.
//   clk : destination clock
//   rst : asynchronous active-high reset; both flops load ResetVal
//   d   : asynchronous input
//   q   : synchronized output (two clk cycles of latency)
module sync2 #(
  parameter logic ResetVal = 1'b1
) (
  input  logic clk,
  input  logic rst,
  input  logic d,
  output logic q
);

  logic meta_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      meta_q <= ResetVal;
      q      <= ResetVal;
    end else begin
      meta_q <= d;
      q      <= meta_q;
    end
  end

endmodule

// File: rtl/uart_rx_oversample.sv
// UART receiver with clock-count oversampling: finds the start-bit edge, samples
// mid-bit, shifts the payload in LSB first and checks the stop bit.
//   clk       : system clock
//   rst       : asynchronous active-high reset
//   rxd       : asynchronous serial line, idle high
//   rx_ack    : consumer acknowledge, clears rx_valid and overrun
//   rx_data   : last correctly framed byte
//   rx_valid  : rx_data holds an unacknowledged byte
//   overrun   : sticky, a byte completed while rx_valid was still set
//   frame_err : one-cycle pulse when the stop bit is sampled low
//   rx_busy   : FSM is not idle
module uart_rx_oversample
  import uart_pkg::*;
#(
  parameter int unsigned CLKS_PER_BIT = CLKS_PER_BIT_DEFAULT,
  parameter int unsigned DATA_BITS    = 8
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 rxd,
  input  logic                 rx_ack,
  output logic [DATA_BITS-1:0] rx_data,
  output logic                 rx_valid,
  output logic                 overrun,
  output logic                 frame_err,
  output logic                 rx_busy
);

  localparam int unsigned CntW = $clog2(CLKS_PER_BIT) + 1;
  localparam int unsigned BitW = $clog2(DATA_BITS + 1);

  localparam logic [CntW-1:0] HalfLast = CntW'(CLKS_PER_BIT / 2 - 1);
  localparam logic [CntW-1:0] FullLast = CntW'(CLKS_PER_BIT - 1);
  localparam logic [BitW-1:0] BitLast  = BitW'(DATA_BITS - 1);

  uart_rx_state_e       state_q;
  logic [CntW-1:0]      cnt_q;
  logic [BitW-1:0]      bit_cnt_q;
  logic [DATA_BITS-1:0] shift_q;
  logic                 rxd_s;

  sync2 #(
    .ResetVal(1'b1)
  ) u_sync2 (
    .clk(clk),
    .rst(rst),
    .d  (rxd),
    .q  (rxd_s)
  );

  assign rx_busy = (state_q != StIdle);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= StIdle;
      cnt_q     <= '0;
      bit_cnt_q <= '0;
      shift_q   <= '0;
      rx_data   <= '0;
      rx_valid  <= 1'b0;
      overrun   <= 1'b0;
      frame_err <= 1'b0;
    end else begin
      frame_err <= 1'b0;

      // An ack only matters while a byte is pending; a good stop in the same
      // cycle overrides the rx_valid clear below.
      if (rx_ack && rx_valid) begin
        rx_valid <= 1'b0;
        overrun  <= 1'b0;
      end

      unique case (state_q)
        StIdle: begin
          cnt_q     <= '0;
          bit_cnt_q <= '0;
          if (!rxd_s) state_q <= StStart;
        end

        StStart: begin
          if (cnt_q == HalfLast) begin
            cnt_q   <= '0;
            // Line back high at mid-start: treat as a glitch.
            state_q <= rxd_s ? StIdle : StData;
          end else begin
            cnt_q <= cnt_q + 1'b1;
          end
        end

        StData: begin
          if (cnt_q == FullLast) begin
            cnt_q   <= '0;
            shift_q <= {rxd_s, shift_q[DATA_BITS-1:1]};
            if (bit_cnt_q == BitLast) begin
              state_q <= StStop;
            end else begin
              bit_cnt_q <= bit_cnt_q + 1'b1;
            end
          end else begin
            cnt_q <= cnt_q + 1'b1;
          end
        end

        StStop: begin
          if (cnt_q == FullLast) begin
            cnt_q <= '0;
            if (rxd_s) begin
              rx_data  <= shift_q;
              rx_valid <= 1'b1;
              if (rx_valid && !rx_ack) overrun <= 1'b1;
              // Re-arm mid-stop so a back-to-back start bit is not missed.
              state_q  <= StIdle;
            end else begin
              frame_err <= 1'b1;
              state_q   <= StWaitHigh;
            end
          end else begin
            cnt_q <= cnt_q + 1'b1;
          end
        end

        StWaitHigh: begin
          // A held-low break must not look like a new start bit.
          if (rxd_s) state_q <= StIdle;
        end

        default: state_q <= StIdle;
      endcase
    end
  end

endmodule

// File: tb/tb_uart_rx_oversample.sv
module tb_uart_rx_oversample;

  localparam int unsigned C = 16;
  localparam int unsigned D = 8;

  logic         clk = 1'b0;
  logic         rst = 1'b1;
  logic         rxd = 1'b1;
  logic         rx_ack = 1'b0;
  logic [D-1:0] rx_data;
  logic         rx_valid;
  logic         overrun;
  logic         frame_err;
  logic         rx_busy;

  always #5 clk = ~clk;

  uart_rx_oversample #(
    .CLKS_PER_BIT(C),
    .DATA_BITS   (D)
  ) dut (
    .clk      (clk),
    .rst      (rst),
    .rxd      (rxd),
    .rx_ack   (rx_ack),
    .rx_data  (rx_data),
    .rx_valid (rx_valid),
    .overrun  (overrun),
    .frame_err(frame_err),
    .rx_busy  (rx_busy)
  );

  int           total = 0;
  int           bad = 0;
  logic [D-1:0] exp_q[$];
  time          t_fall = 0;
  int           ferr_cycles = 0;
  int           busy_run = 0;
  int           max_busy = 0;
  bit           win = 1'b0;
  logic         vprev = 1'b0;
  logic [D-1:0] dprev = '0;
  logic [D-1:0] e;
  longint       lat;
  int           ferr_base;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp)
    else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic drive_bit(input logic b);
    rxd = b;
    tick(C);
  endtask

  task automatic send_frame(input logic [D-1:0] d, input logic stop);
    t_fall = $time;
    drive_bit(1'b0);
    for (int i = 0; i < D; i++) drive_bit(d[i]);
    drive_bit(stop);
    rxd = 1'b1;
  endtask

  // Monitor: a new byte is a rising rx_valid or a fresh rx_data while valid.
  always @(negedge clk) begin
    if (frame_err) ferr_cycles++;
    if (rx_busy) busy_run++;
    else busy_run = 0;
    if (win && busy_run > max_busy) max_busy = busy_run;
    if (rx_valid && (!vprev || rx_data !== dprev)) begin
      if (exp_q.size() == 0) begin
        chk("pending_on_byte", exp_q.size(), 1);
      end else begin
        e = exp_q.pop_front();
        chk("rx_data_byte", {24'h0, rx_data}, {24'h0, e});
        lat = longint'(($time - 5 - t_fall) / 10);
        total++;
        assert (lat >= 153 && lat <= 155)
        else begin
          bad++;
          $error("FAIL latency observed=%0d expected=154+/-1", lat);
        end
      end
    end
    vprev = rx_valid;
    dprev = rx_data;
  end

  initial begin
    // Reset state.
    tick(3);
    chk("rst_rx_valid", rx_valid, 0);
    chk("rst_rx_data", {24'h0, rx_data}, 0);
    chk("rst_overrun", overrun, 0);
    chk("rst_frame_err", frame_err, 0);
    chk("rst_rx_busy", rx_busy, 0);
    rst = 1'b0;
    tick(5);
    chk("idle_busy", rx_busy, 0);

    // Good frame 0xA5.
    exp_q.push_back(8'hA5);
    send_frame(8'hA5, 1'b1);
    tick(5);
    chk("a5_data", {24'h0, rx_data}, 32'hA5);
    chk("a5_valid", rx_valid, 1);
    chk("a5_overrun", overrun, 0);
    chk("a5_no_ferr", ferr_cycles, 0);
    rx_ack = 1'b1;
    tick(1);
    rx_ack = 1'b0;
    chk("a5_ack_valid", rx_valid, 0);
    chk("a5_ack_data_kept", {24'h0, rx_data}, 32'hA5);
    tick(3);

    // Start-bit glitch: 4 cycles low.
    win = 1'b1;
    rxd = 1'b0;
    tick(4);
    rxd = 1'b1;
    tick(30);
    win = 1'b0;
    chk("glitch_busy", rx_busy, 0);
    chk("glitch_valid", rx_valid, 0);
    total++;
    assert (max_busy >= 1 && max_busy <= 12)
    else begin
      bad++;
      $error("FAIL glitch_busy_len observed=%0d expected=1..12", max_busy);
    end

    // Framing error on 0x3C, then line held low.
    ferr_base = ferr_cycles;
    send_frame(8'h3C, 1'b0);
    rxd = 1'b0;
    tick(40);
    chk("ferr_pulse", ferr_cycles - ferr_base, 1);
    chk("ferr_valid", rx_valid, 0);
    chk("ferr_wait_busy", rx_busy, 1);
    rxd = 1'b1;
    tick(4);
    chk("ferr_release_idle", rx_busy, 0);
    tick(20);
    chk("ferr_no_repeat", ferr_cycles - ferr_base, 1);
    chk("ferr_data_kept", {24'h0, rx_data}, 32'hA5);

    // Back-to-back 0x11, 0x22 without ack.
    exp_q.push_back(8'h11);
    send_frame(8'h11, 1'b1);
    exp_q.push_back(8'h22);
    send_frame(8'h22, 1'b1);
    tick(5);
    chk("b2b_data", {24'h0, rx_data}, 32'h22);
    chk("b2b_valid", rx_valid, 1);
    chk("b2b_overrun", overrun, 1);
    rx_ack = 1'b1;
    tick(1);
    rx_ack = 1'b0;
    chk("b2b_ack_valid", rx_valid, 0);
    chk("b2b_ack_overrun", overrun, 0);
    tick(3);

    // Reset during bit 4 of 0xFF, then a clean 0x5A.
    ferr_base = ferr_cycles;
    drive_bit(1'b0);
    for (int i = 0; i < 4; i++) drive_bit(1'b1);
    rxd = 1'b1;
    tick(5);
    rst = 1'b1;
    tick(2);
    chk("midrst_busy", rx_busy, 0);
    chk("midrst_data", {24'h0, rx_data}, 0);
    rst = 1'b0;
    tick(C - 7);
    for (int i = 0; i < 4; i++) drive_bit(1'b1);
    tick(5);
    chk("midrst_idle", rx_busy, 0);
    chk("midrst_valid", rx_valid, 0);
    exp_q.push_back(8'h5A);
    send_frame(8'h5A, 1'b1);
    tick(5);
    chk("rst_frame_data", {24'h0, rx_data}, 32'h5A);
    chk("rst_frame_valid", rx_valid, 1);
    chk("rst_frame_overrun", overrun, 0);
    chk("rst_frame_no_ferr", ferr_cycles - ferr_base, 0);

    chk("scoreboard_drained", exp_q.size(), 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
